// File: rtl/gray_pack_unit_if.sv
// Pixel stream and data-memory write port of gray_pack_unit.
// master is the packing unit; slave is the pixel source and memory around it.
interface gray_pack_unit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_ready;

  modport master (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/gray_pack_unit.sv
// Saturates averaged grey pixels to 8 bits, packs four per word little-endian
// and writes each word to consecutive memory addresses, one frame per start.
module gray_pack_unit #(
  parameter int          N         = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          PIXELS    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  gray_pack_unit_if.master    bus,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PACK   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [20:0]  PIX_TOTAL = 21'(PIXELS);
  localparam logic [N-1:0] ADDR_BASE = N'(BASE_ADDR);
  localparam logic [N-1:0] ADDR_STEP = N'(3'd4);

  state_t      state;
  state_t      state_nxt;
  logic [N-1:0] addr;
  logic [31:0] word;
  logic [31:0] word_nxt;
  logic [1:0]  lane;
  logic [20:0] pix_cnt;
  logic [20:0] pix_cnt_inc;
  logic [7:0]  pix_sat;
  logic        accept;
  logic        word_full;
  logic        unused_in_hi;

  function automatic logic [7:0] sat8(input logic [9:0] v);
    if (v[9:8] != 2'b00) begin
      sat8 = 8'hFF;
    end else begin
      sat8 = v[7:0];
    end
  endfunction

  assign unused_in_hi = ^bus.in_data[N-1:10];
  assign bus.mem_addr = addr;

  // Next-state decode and the word as it looks once the incoming pixel lands
  always_comb begin
    pix_sat     = sat8(bus.in_data[9:0]);
    accept      = bus.in_valid & bus.in_ready;
    pix_cnt_inc = pix_cnt + 21'd1;
    word_nxt    = word;
    word_nxt[{lane, 3'b000} +: 8] = pix_sat;
    word_full   = (lane == 2'd3) | (pix_cnt_inc == PIX_TOTAL);
    state_nxt   = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      PACK: begin
        if (accept && word_full) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = PACK;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          state_nxt = (pix_cnt == PIX_TOTAL) ? FINISH : PACK;
        end else begin
          state_nxt = WRITE;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs follow the next state)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      addr          <= {N{1'b0}};
      word          <= 32'd0;
      lane          <= 2'd0;
      pix_cnt       <= 21'd0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= {N{1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.in_ready <= (state_nxt == PACK);
      bus.mem_we   <= (state_nxt == WRITE);
      busy         <= (state_nxt != IDLE);
      done         <= (state_nxt == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            addr    <= ADDR_BASE;
            word    <= 32'd0;
            lane    <= 2'd0;
            pix_cnt <= 21'd0;
          end
        end
        PACK: begin
          if (accept) begin
            word    <= word_nxt;
            lane    <= lane + 2'd1;
            pix_cnt <= pix_cnt_inc;
            // Unfilled lanes of a short last word are still zero in word_nxt
            if (word_full) begin
              bus.mem_wdata <= N'(word_nxt);
            end
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            addr <= addr + ADDR_STEP;
            word <= 32'd0;
          end
        end
        FINISH: begin
          word <= 32'd0;
        end
        default: begin
          word <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_pack_unit.sv
// Self-checking bench: two instances (4- and 6-pixel frames) driven one at a time
// through table vectors, reset sequences and random frames against a packing model.
module tb_gray_pack_unit;

  localparam logic [31:0] BASE4 = 32'h0000_0100;
  localparam logic [31:0] BASE6 = 32'hFFFF_FFFC;

  typedef struct packed {
    logic            use6;
    logic [5:0][31:0] pix;
    logic [31:0]     w0;
    logic [31:0]     w1;
    logic [1:0]      gap;
    logic [1:0]      bp;
    logic            noise;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        mem_ready;
  logic        sel;
  logic [31:0] in_data;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pix_q[$];
  logic [31:0] exp_q[$];
  vec_t        tbl[7];

  logic busy4, done4, busy6, done6;
  logic o_ready, o_we, o_busy, o_done;
  logic [31:0] o_addr, o_wdata;

  always #5 clk = ~clk;

  gray_pack_unit_if #(.N(32)) if4 ();
  gray_pack_unit_if #(.N(32)) if6 ();

  assign if4.in_valid  = in_valid & ~sel;
  assign if4.in_data   = in_data;
  assign if4.mem_ready = mem_ready & ~sel;
  assign if6.in_valid  = in_valid & sel;
  assign if6.in_data   = in_data;
  assign if6.mem_ready = mem_ready & sel;

  gray_pack_unit #(.N(32), .BASE_ADDR(BASE4), .PIXELS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start & ~sel), .bus(if4), .busy(busy4), .done(done4)
  );
  gray_pack_unit #(.N(32), .BASE_ADDR(BASE6), .PIXELS(6)) dut6 (
    .clk(clk), .rst(rst), .start(start & sel), .bus(if6), .busy(busy6), .done(done6)
  );

  assign o_ready = sel ? if6.in_ready  : if4.in_ready;
  assign o_we    = sel ? if6.mem_we    : if4.mem_we;
  assign o_addr  = sel ? if6.mem_addr  : if4.mem_addr;
  assign o_wdata = sel ? if6.mem_wdata : if4.mem_wdata;
  assign o_busy  = sel ? busy6 : busy4;
  assign o_done  = sel ? done6 : done4;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic u6,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input logic [31:0] p4, input logic [31:0] p5,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [1:0] gap, input logic [1:0] bp, input logic noise);
    tbl[i].use6 = u6;
    tbl[i].pix[0] = p0; tbl[i].pix[1] = p1; tbl[i].pix[2] = p2;
    tbl[i].pix[3] = p3; tbl[i].pix[4] = p4; tbl[i].pix[5] = p5;
    tbl[i].w0 = w0; tbl[i].w1 = w1;
    tbl[i].gap = gap; tbl[i].bp = bp; tbl[i].noise = noise;
  endtask

  // Reference: saturate each pixel's low 10 bits and add it at byte (i mod 4) of word i/4
  task automatic build_expect();
    int unsigned v;
    exp_q.delete();
    for (int w = 0; w < (pix_q.size() + 3) / 4; w++) exp_q.push_back(32'd0);
    for (int i = 0; i < pix_q.size(); i++) begin
      v = pix_q[i] % 1024;
      if (v > 255) v = 255;
      exp_q[i / 4] = exp_q[i / 4] + (v << (8 * (i % 4)));
    end
  endtask

  task automatic run_frame(input logic use6, input int gap_mode, input int bp_mode, input logic noise);
    int npix, pidx, widx, cyc, bp_cnt;
    logic [31:0] base, prev_addr, prev_data;
    logic prev_full, prev_we, prev_rdy, prev_final, prev_mid, prev_done, finished, acc, wacc;
    npix = use6 ? 6 : 4;
    base = use6 ? BASE6 : BASE4;
    pidx = 0; widx = 0; cyc = 0; bp_cnt = 0;
    prev_full = 1'b0; prev_we = 1'b0; prev_rdy = 1'b0; prev_final = 1'b0;
    prev_mid = 1'b0; prev_done = 1'b0; finished = 1'b0;
    prev_addr = 32'd0; prev_data = 32'd0;
    sel = use6;
    @(negedge clk);
    chk_b("idle_before_start", o_busy, 1'b0);
    chk_b("ready_in_start_cycle", o_ready, 1'b0);
    start = 1'b1; in_valid = 1'b1; in_data = pix_q[0]; mem_ready = 1'b1;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk_b("busy_after_start", o_busy, 1'b1);
        chk_b("ready_after_start", o_ready, 1'b1);
      end
      if (prev_full) chk_b("we_latency", o_we, 1'b1);
      if (prev_we && !prev_rdy) begin
        chk_b("hold_we", o_we, 1'b1);
        chk32("hold_addr", o_addr, prev_addr);
        chk32("hold_data", o_wdata, prev_data);
      end
      if (prev_mid) chk_b("ready_after_write", o_ready, 1'b1);
      chk_b("done_pulse", o_done, prev_final);
      chk_b("ready_we_exclusive", o_ready & o_we, 1'b0);
      if (prev_final) chk_b("busy_in_finish", o_busy, 1'b1);
      if (prev_done) begin
        chk_b("busy_after_done", o_busy, 1'b0);
        finished = 1'b1;
      end else begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (gap_mode == 0) in_valid = 1'b1;
        else if (gap_mode == 1) in_valid = (cyc % 2 == 0);
        else in_valid = 1'($urandom_range(0, 1));
        in_data = (pidx < npix) ? pix_q[pidx] : 32'h0000_03FF;
        if (o_we) bp_cnt++;
        else bp_cnt = 0;
        if (bp_mode == 0) mem_ready = 1'b1;
        else if (bp_mode == 1) mem_ready = (bp_cnt >= 4);
        else mem_ready = 1'($urandom_range(0, 1));
        acc = o_ready & in_valid;
        if (acc) pidx++;
        prev_full = acc && ((pidx % 4 == 0) || (pidx == npix));
        wacc = o_we & mem_ready;
        if (wacc) begin
          chk32("write_addr", o_addr, base + 32'(4 * widx));
          chk32("write_data", o_wdata, (widx < exp_q.size()) ? exp_q[widx] : 32'hDEAD_BEEF);
          widx++;
        end
        prev_final = wacc && (widx == exp_q.size());
        prev_mid   = wacc && !prev_final;
        prev_we = o_we; prev_rdy = mem_ready; prev_addr = o_addr; prev_data = o_wdata;
        prev_done = o_done;
      end
    end
    start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    chk_b("frame_finished", finished, 1'b1);
    chk32("pixels_consumed", 32'(pidx), 32'(npix));
    chk32("words_written", 32'(widx), 32'(exp_q.size()));
  endtask

  task automatic mid_reset(input logic use6, input int nfeed);
    int fed, guard;
    fed = 0; guard = 0;
    sel = use6;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (fed < nfeed && guard < 40) begin
      in_valid = 1'b1; in_data = 32'(fed + 5);
      if (o_ready) fed++;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk32("fed_before_reset", 32'(fed), 32'(nfeed));
    chk_b("busy_before_reset", o_busy, 1'b1);
    if (nfeed == 4) chk_b("write_pending", o_we, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk_b("rst_ready", o_ready, 1'b0);
    chk_b("rst_we", o_we, 1'b0);
    chk_b("rst_busy", o_busy, 1'b0);
    chk_b("rst_done", o_done, 1'b0);
    chk32("rst_addr", o_addr, 32'd0);
    chk32("rst_wdata", o_wdata, 32'd0);
    rst = 1'b1; in_valid = 1'b1; mem_ready = 1'b1; in_data = 32'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk32("quiet_after_reset", {28'd0, o_we, o_done, o_busy, o_ready}, 32'd0);
    end
    in_valid = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic u6;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 32'd0; mem_ready = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk_b("reset_ready4", if4.in_ready, 1'b0);
    chk_b("reset_we4", if4.mem_we, 1'b0);
    chk_b("reset_busy4", busy4, 1'b0);
    chk_b("reset_done4", done4, 1'b0);
    chk32("reset_addr4", if4.mem_addr, 32'd0);
    chk32("reset_wdata4", if4.mem_wdata, 32'd0);
    chk_b("reset_ready6", if6.in_ready, 1'b0);
    chk_b("reset_we6", if6.mem_we, 1'b0);
    chk_b("reset_busy6", busy6, 1'b0);
    chk_b("reset_done6", done6, 1'b0);
    chk32("reset_addr6", if6.mem_addr, 32'd0);
    chk32("reset_wdata6", if6.mem_wdata, 32'd0);
    rst = 1'b1;

    set_vec(0, 1'b0, 32'd10, 32'd20, 32'd30, 32'd40, 32'd0, 32'd0,
            32'h281E_140A, 32'd0, 2'd0, 2'd0, 1'b0);
    set_vec(1, 1'b0, 32'd700, 32'd255, 32'd0, 32'd256, 32'd0, 32'd0,
            32'hFF00_FFFF, 32'd0, 2'd0, 2'd0, 1'b0);
    set_vec(2, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
            32'h0403_0201, 32'h0000_0605, 2'd0, 2'd0, 1'b0);
    set_vec(3, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
            32'h0403_0201, 32'h0000_0605, 2'd1, 2'd0, 1'b0);
    set_vec(4, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
            32'h0403_0201, 32'h0000_0605, 2'd0, 2'd1, 1'b0);
    set_vec(5, 1'b0, 32'd10, 32'd20, 32'd30, 32'd40, 32'd0, 32'd0,
            32'h281E_140A, 32'd0, 2'd1, 2'd1, 1'b1);
    set_vec(6, 1'b1, 32'hFFFF_FC05, 32'h0000_0100, 32'h8000_00FF, 32'h0000_03FF, 32'h0000_0080, 32'h0000_0200,
            32'hFFFF_FF05, 32'h0000_FF80, 2'd0, 2'd0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      pix_q.delete();
      exp_q.delete();
      for (int k = 0; k < (tbl[i].use6 ? 6 : 4); k++) pix_q.push_back(tbl[i].pix[k]);
      exp_q.push_back(tbl[i].w0);
      if (tbl[i].use6) exp_q.push_back(tbl[i].w1);
      run_frame(tbl[i].use6, int'(tbl[i].gap), int'(tbl[i].bp), tbl[i].noise);
    end

    mid_reset(1'b1, 2);
    pix_q.delete();
    for (int k = 1; k <= 6; k++) pix_q.push_back(32'(k));
    exp_q.delete();
    exp_q.push_back(32'h0403_0201);
    exp_q.push_back(32'h0000_0605);
    run_frame(1'b1, 0, 0, 1'b0);

    mid_reset(1'b0, 4);
    pix_q.delete();
    pix_q.push_back(32'd10); pix_q.push_back(32'd20); pix_q.push_back(32'd30); pix_q.push_back(32'd40);
    exp_q.delete();
    exp_q.push_back(32'h281E_140A);
    run_frame(1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      u6 = 1'($urandom_range(0, 1));
      pix_q.delete();
      for (int k = 0; k < (u6 ? 6 : 4); k++) begin
        if ($urandom_range(0, 3) == 0) pix_q.push_back($urandom());
        else pix_q.push_back(32'($urandom_range(0, 1023)));
      end
      build_expect();
      run_frame(u6, 2, 2, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
